// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and frame geometry shared by the UART blocks.
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO; a full FIFO drops a push unless a pop
// frees the slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign overrun = push & full & ~do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver sampling each bit at its centre, with framing and
// overrun detection and a show-ahead receive FIFO toward the CPU side.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun_err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] ONE  = CW'(1);
    uart_state_t state;
    logic sync1, rx_s, push, full, empty;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end
    // cnt counts down to 1; the action fires on the cycle it reads 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            push        <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            push        <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state   <= START;
                    bit_cnt <= '0;
                    cnt     <= HALF;
                end
                START: if (cnt == ONE) begin
                    state <= rx_s ? IDLE : DATA;
                    cnt   <= FULL;
                end else cnt <= cnt - ONE;
                DATA: if (cnt == ONE) begin
                    shift   <= {rx_s, shift[DATA_BITS-1:1]};
                    cnt     <= FULL;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
                end else cnt <= cnt - ONE;
                STOP: if (cnt == ONE) begin
                    push        <= rx_s;
                    framing_err <= ~rx_s;
                    state       <= rx_s ? IDLE : WAIT_IDLE;
                end else cnt <= cnt - ONE;
                WAIT_IDLE: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (rd_en),
        .din    (shift),
        .head   (rx_data),
        .full   (full),
        .empty  (empty),
        .overrun(overrun_err)
    );
    assign rx_valid = ~empty;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;
    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rd_en = 1'b0;
    logic [7:0] rx_data;
    logic rx_valid, framing_err, overrun_err;
    int total = 0, bad = 0, fe_cnt = 0, ov_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .framing_err(framing_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_err === 1'b1) fe_cnt++;
        if (overrun_err === 1'b1) ov_cnt++;
    end

    // drives ncyc bit-clocks of a frame; rd_en is raised for exactly bit-clock pop_at
    task automatic send(input logic [7:0] d, input logic stop, input int pop_at, input int ncyc);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            rx = f[k / CPB];
            rd_en = (k == pop_at);
        end
        @(negedge clk);
        rd_en = 1'b0;
        rx = stop;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", framing_err); end
        total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL reset_oerr got=%b exp=0", overrun_err); end
    endtask

    task automatic test_basic();
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send(8'hA5, 1'b1, -1, 160);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", rx_data); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL basic_ferr got=%0d exp=0", fe_cnt - fe0); end
        total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL basic_oerr got=%0d exp=0", ov_cnt - ov0); end
        pop();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid got=%b exp=0", rx_valid); end
    endtask

    task automatic test_false_start();
        int fe0;
        fe0 = fe_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL false_valid got=%b exp=0", rx_valid); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL false_ferr got=%0d exp=0", fe_cnt - fe0); end
        send(8'h5A, 1'b1, -1, 160);
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL false_next got=%h exp=5a", rx_data); end
        pop();
    endtask

    task automatic test_framing();
        int fe0;
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, -1, 160);
        repeat (40) @(negedge clk);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_ferr got=%0d exp=1", fe_cnt - fe0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL frame_valid got=%b exp=0", rx_valid); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h81, 1'b1, -1, 160);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL frame_next_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL frame_next_data got=%h exp=81", rx_data); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_next_ferr got=%0d exp=1", fe_cnt - fe0); end
        pop();
    endtask

    task automatic test_overrun();
        int ov0;
        logic [7:0] exp;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, 160);
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt - ov0); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            total++; if (rx_data !== exp || rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_pop%0d got=%h/%b exp=%h/1", i, rx_data, rx_valid, exp); end
            pop();
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got=%b exp=0", rx_valid); end
    endtask

    task automatic test_push_pop_full();
        int ov0;
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h55};
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1, 160);
        send(8'h55, 1'b1, 155, 160);
        total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL ppf_oerr got=%0d exp=0", ov_cnt - ov0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rx_data !== exp_q[i] || rx_valid !== 1'b1) begin bad++; $display("FAIL ppf_pop%0d got=%h/%b exp=%h/1", i, rx_data, rx_valid, exp_q[i]); end
            pop();
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ppf_empty got=%b exp=0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        send(8'h11, 1'b1, -1, 160);
        send(8'hFF, 1'b1, -1, 60);
        rst = 1'b0;
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", rx_data); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h42, 1'b1, -1, 160);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h42) begin bad++; $display("FAIL rmid_next_data got=%h exp=42", rx_data); end
        pop();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_empty got=%b exp=0", rx_valid); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_basic();
        test_false_start();
        test_framing();
        test_overrun();
        test_push_pop_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
